// File: rtl/myo_pwm_generator.sv
// rtl/myo_pwm_generator.sv - signed duty to two-channel H-bridge PWM with dead time
// Emits a once-per-period strobe that paces the upstream PID controller update.
module myo_pwm_generator #(
    parameter int unsigned PERIOD      = 2500,
    parameter int unsigned DEAD_CYCLES = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pwm_ref,
    input  logic        enable,
    output logic        period_tick,
    output logic        pwm_a,
    output logic        pwm_b,
    output logic        dir,
    output logic [15:0] duty_active
);

    localparam logic [16:0] PERIOD_17 = 17'(PERIOD);
    localparam logic [15:0] LAST_CNT  = 16'(PERIOD - 1);
    localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_RUN,
        ST_DEADTIME
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] dead_q, dead_d;
    logic [15:0] duty_q, duty_d;
    logic        dir_q, dir_d;
    logic        tick_q, tick_d;
    logic        pwm_a_q, pwm_a_d;
    logic        pwm_b_q, pwm_b_d;

    logic        boundary;
    logic [16:0] ref_ext;
    logic [16:0] ref_mag;
    logic [15:0] duty_new;
    logic        req_dir;
    logic        reversal;
    logic        run_out;

    always_comb begin
        boundary = (cnt_q == LAST_CNT);
        cnt_d    = boundary ? 16'd0 : cnt_q + 16'd1;
        tick_d   = boundary;

        // 17-bit magnitude so that -32768 maps to +32768 before clipping.
        ref_ext  = {pwm_ref[15], pwm_ref};
        ref_mag  = pwm_ref[15] ? (~ref_ext + 17'd1) : ref_ext;
        duty_new = (ref_mag > PERIOD_17) ? PERIOD_17[15:0] : ref_mag[15:0];
        req_dir  = (pwm_ref == 16'd0) ? dir_q : pwm_ref[15];
        reversal = boundary && (req_dir != dir_q) && (duty_new != 16'd0);

        duty_d  = boundary ? duty_new : duty_q;
        state_d = state_q;
        dir_d   = dir_q;
        dead_d  = 16'd0;

        case (state_q)
            ST_DISABLED: begin
                if (boundary) begin
                    state_d = ST_DEADTIME;
                    dir_d   = req_dir;
                end
            end
            ST_RUN: begin
                if (reversal) begin
                    state_d = ST_DEADTIME;
                    dir_d   = req_dir;
                end
            end
            ST_DEADTIME: begin
                if (reversal) begin
                    dir_d = req_dir;
                end else if (dead_q == DEAD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    dead_d = dead_q + 16'd1;
                end
            end
            default: state_d = ST_DISABLED;
        endcase

        if (!enable) begin
            state_d = ST_DISABLED;
            dir_d   = dir_q;
            dead_d  = 16'd0;
        end

        run_out = enable && (state_q == ST_RUN) && (cnt_q < duty_q);
        pwm_a_d = run_out && !dir_q;
        pwm_b_d = run_out && dir_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_DISABLED;
            cnt_q   <= 16'd0;
            dead_q  <= 16'd0;
            duty_q  <= 16'd0;
            dir_q   <= 1'b0;
            tick_q  <= 1'b0;
            pwm_a_q <= 1'b0;
            pwm_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dead_q  <= dead_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
            pwm_a_q <= pwm_a_d;
            pwm_b_q <= pwm_b_d;
        end
    end

    assign period_tick = tick_q;
    assign pwm_a       = pwm_a_q;
    assign pwm_b       = pwm_b_q;
    assign dir         = dir_q;
    assign duty_active = duty_q;

endmodule

// File: tb/tb_myo_pwm_generator.sv
// tb/tb_myo_pwm_generator.sv - directed self-checking bench for myo_pwm_generator
module tb_myo_pwm_generator;

    localparam int P = 100;
    localparam int D = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] pwm_ref = 16'd0;
    logic        period_tick;
    logic        pwm_a;
    logic        pwm_b;
    logic        dir;
    logic [15:0] duty_active;

    int n_cmp = 0;
    int n_bad = 0;
    int tb_cnt = 0;

    always #5 clock = ~clock;

    myo_pwm_generator #(.PERIOD(P), .DEAD_CYCLES(D)) dut (
        .clock       (clock),
        .reset       (reset),
        .pwm_ref     (pwm_ref),
        .enable      (enable),
        .period_tick (period_tick),
        .pwm_a       (pwm_a),
        .pwm_b       (pwm_b),
        .dir         (dir),
        .duty_active (duty_active)
    );

    // Reference period position, independent of the DUT counter.
    always @(posedge clock) begin
        if (reset) tb_cnt <= 0;
        else       tb_cnt <= (tb_cnt == P - 1) ? 0 : tb_cnt + 1;
    end

    typedef struct packed {
        logic [7:0]  na;
        logic [7:0]  nb;
        logic [7:0]  fa;
        logic [7:0]  fb;
        logic        dr;
        logic [15:0] duty;
        logic        tick_ok;
        logic        no_ovl;
    } win_t;

    function automatic string fmt(input win_t w);
        return $sformatf("na=%0d nb=%0d fa=%0d fb=%0d dir=%0d duty=%0d tick_ok=%0d no_ovl=%0d",
                         w.na, w.nb, w.fa, w.fb, w.dr, w.duty, w.tick_ok, w.no_ovl);
    endfunction

    function automatic win_t mk(input int na, input int nb, input int fa, input int fb,
                                input logic dr, input int duty);
        win_t w;
        w.na      = 8'(na);
        w.nb      = 8'(nb);
        w.fa      = 8'(fa);
        w.fb      = 8'(fb);
        w.dr      = dr;
        w.duty    = 16'(duty);
        w.tick_ok = 1'b1;
        w.no_ovl  = 1'b1;
        return w;
    endfunction

    // Observes one period window (outputs for cnt 0..P-1 appear at tb_cnt 1..P-1,0).
    task automatic measure(input int ref_at, input logic [15:0] ref_val,
                           input int en_at, input logic en_val, output win_t w);
        w         = '0;
        w.fa      = 8'hFF;
        w.fb      = 8'hFF;
        w.tick_ok = 1'b1;
        w.no_ovl  = 1'b1;
        for (int i = 0; i < P; i++) begin
            @(negedge clock);
            if (pwm_a === 1'b1) begin
                if (w.fa == 8'hFF) w.fa = 8'(tb_cnt);
                w.na = w.na + 8'd1;
            end
            if (pwm_b === 1'b1) begin
                if (w.fb == 8'hFF) w.fb = 8'(tb_cnt);
                w.nb = w.nb + 8'd1;
            end
            if (period_tick !== (tb_cnt == 0)) w.tick_ok = 1'b0;
            if (pwm_a === 1'b1 && pwm_b === 1'b1) w.no_ovl = 1'b0;
            if (tb_cnt == ref_at) pwm_ref = ref_val;
            if (tb_cnt == en_at) enable = en_val;
        end
        w.dr   = dir;
        w.duty = duty_active;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        enable  = 1'b0;
        pwm_ref = 16'd0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({pwm_a, pwm_b, period_tick, dir, duty_active} !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_state got a=%b b=%b tick=%b dir=%b duty=%0d want all 0",
                     pwm_a, pwm_b, period_tick, dir, duty_active);
        end
        reset   = 1'b0;
        enable  = 1'b1;
        pwm_ref = 16'd40;
    endtask

    task automatic test_forward();
        win_t w;
        win_t e[3];
        e[0] = mk(0, 0, 255, 255, 1'b0, 40);
        e[1] = mk(35, 0, 6, 255, 1'b0, 40);
        e[2] = mk(40, 0, 1, 255, 1'b0, 40);
        for (int k = 0; k < 3; k++) begin
            measure(-1, 16'd0, -1, 1'b0, w);
            n_cmp++;
            if (w !== e[k]) begin
                n_bad++;
                $display("FAIL forward_p%0d got %s want %s", k, fmt(w), fmt(e[k]));
            end
        end
    endtask

    task automatic test_reverse();
        win_t w;
        win_t e[2];
        int ra[2];
        logic [15:0] rv[2];
        ra[0] = 50; rv[0] = 16'(-30); e[0] = mk(40, 0, 1, 255, 1'b1, 30);
        ra[1] = -1; rv[1] = 16'd0;    e[1] = mk(0, 25, 255, 6, 1'b1, 30);
        for (int k = 0; k < 2; k++) begin
            measure(ra[k], rv[k], -1, 1'b0, w);
            n_cmp++;
            if (w !== e[k]) begin
                n_bad++;
                $display("FAIL reverse_p%0d got %s want %s", k, fmt(w), fmt(e[k]));
            end
        end
    endtask

    task automatic test_full_scale();
        win_t w;
        win_t e[3];
        int ra[3];
        logic [15:0] rv[3];
        ra[0] = 50; rv[0] = 16'd150;  e[0] = mk(0, 30, 255, 1, 1'b0, 100);
        ra[1] = 50; rv[1] = 16'h8000; e[1] = mk(95, 0, 6, 255, 1'b1, 100);
        ra[2] = 50; rv[2] = 16'(-30); e[2] = mk(0, 95, 255, 6, 1'b1, 30);
        for (int k = 0; k < 3; k++) begin
            measure(ra[k], rv[k], -1, 1'b0, w);
            n_cmp++;
            if (w !== e[k]) begin
                n_bad++;
                $display("FAIL full_scale_p%0d got %s want %s", k, fmt(w), fmt(e[k]));
            end
        end
    endtask

    task automatic test_zero_duty();
        win_t w;
        win_t e[5];
        int ra[5];
        logic [15:0] rv[5];
        ra[0] = 50; rv[0] = 16'd0;    e[0] = mk(0, 30, 255, 1, 1'b1, 0);
        ra[1] = 50; rv[1] = 16'(-20); e[1] = mk(0, 0, 255, 255, 1'b1, 20);
        ra[2] = 50; rv[2] = 16'd40;   e[2] = mk(0, 20, 255, 1, 1'b0, 40);
        ra[3] = -1; rv[3] = 16'd0;    e[3] = mk(35, 0, 6, 255, 1'b0, 40);
        ra[4] = -1; rv[4] = 16'd0;    e[4] = mk(40, 0, 1, 255, 1'b0, 40);
        for (int k = 0; k < 5; k++) begin
            measure(ra[k], rv[k], -1, 1'b0, w);
            n_cmp++;
            if (w !== e[k]) begin
                n_bad++;
                $display("FAIL zero_duty_p%0d got %s want %s", k, fmt(w), fmt(e[k]));
            end
        end
    endtask

    task automatic test_enable();
        win_t w;
        win_t e[4];
        int ea[4];
        logic ev[4];
        ea[0] = 10; ev[0] = 1'b0; e[0] = mk(10, 0, 1, 255, 1'b0, 40);
        ea[1] = 20; ev[1] = 1'b1; e[1] = mk(0, 0, 255, 255, 1'b0, 40);
        ea[2] = -1; ev[2] = 1'b1; e[2] = mk(35, 0, 6, 255, 1'b0, 40);
        ea[3] = -1; ev[3] = 1'b1; e[3] = mk(40, 0, 1, 255, 1'b0, 40);
        for (int k = 0; k < 4; k++) begin
            measure(-1, 16'd0, ea[k], ev[k], w);
            n_cmp++;
            if (w !== e[k]) begin
                n_bad++;
                $display("FAIL enable_p%0d got %s want %s", k, fmt(w), fmt(e[k]));
            end
        end
    endtask

    task automatic test_reset_mid();
        win_t w;
        win_t e[2];
        int guard = 0;
        while (tb_cnt != 50 && guard < 2 * P) begin
            @(negedge clock);
            guard++;
        end
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({pwm_a, pwm_b, period_tick, dir, duty_active} !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_mid got a=%b b=%b tick=%b dir=%b duty=%0d want all 0",
                     pwm_a, pwm_b, period_tick, dir, duty_active);
        end
        reset = 1'b0;
        e[0] = mk(0, 0, 255, 255, 1'b0, 40);
        e[1] = mk(35, 0, 6, 255, 1'b0, 40);
        for (int k = 0; k < 2; k++) begin
            measure(-1, 16'd0, -1, 1'b0, w);
            n_cmp++;
            if (w !== e[k]) begin
                n_bad++;
                $display("FAIL reset_mid_p%0d got %s want %s", k, fmt(w), fmt(e[k]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_full_scale();
        test_zero_duty();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
